// File: rtl/id_pipe.sv
// Instruction-decode stage: decodes a MIPS-style subset, resolves operands through
// a priority forwarding network, stalls on load-use hazards and registers the bundle.
module id_pipe #(
   parameter int DATA_W  = 32,
   parameter int RA_W    = 5,
   parameter int NUM_FWD = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [31:0]               in_pc,
   input  logic [31:0]               in_inst,
   output logic                      rf_re1,
   output logic                      rf_re2,
   output logic [RA_W-1:0]           rf_ra1,
   output logic [RA_W-1:0]           rf_ra2,
   input  logic [DATA_W-1:0]         rf_rd1,
   input  logic [DATA_W-1:0]         rf_rd2,
   input  logic [NUM_FWD-1:0]        fwd_wen,
   input  logic [NUM_FWD-1:0]        fwd_is_load,
   input  logic [NUM_FWD*RA_W-1:0]   fwd_waddr,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [7:0]                out_aluop,
   output logic [2:0]                out_alusel,
   output logic [DATA_W-1:0]         out_src1,
   output logic [DATA_W-1:0]         out_src2,
   output logic [RA_W-1:0]           out_wd,
   output logic                      out_wreg,
   output logic [31:0]               out_pc,
   output logic                      out_invalid,
   output logic [15:0]               stall_cnt
);

   localparam logic [7:0] OP_NOP = 8'h00, OP_AND = 8'h24, OP_OR  = 8'h25, OP_XOR = 8'h26;
   localparam logic [7:0] OP_NOR = 8'h27, OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03;
   localparam logic [2:0] SEL_NOP = 3'd0, SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  sa;
   logic [15:0] imm16;
   assign opcode = in_inst[31:26];
   assign funct  = in_inst[5:0];
   assign sa     = in_inst[10:6];
   assign imm16  = in_inst[15:0];

   assign rf_ra1 = RA_W'(in_inst[25:21]);
   assign rf_ra2 = RA_W'(in_inst[20:16]);

   logic [7:0]        dec_aluop;
   logic [2:0]        dec_alusel;
   logic              dec_wreg;
   logic              dec_invalid;
   logic [RA_W-1:0]   dec_wd;
   logic [DATA_W-1:0] imm1;
   logic [DATA_W-1:0] imm2;

   always_comb begin
      dec_aluop   = OP_NOP;
      dec_alusel  = SEL_NOP;
      dec_wreg    = 1'b0;
      dec_invalid = 1'b1;
      dec_wd      = RA_W'(in_inst[15:11]);
      imm1        = '0;
      imm2        = '0;
      rf_re1      = 1'b0;
      rf_re2      = 1'b0;
      case (opcode)
         6'h00: begin
            if (in_inst[25:21] == 5'd0 && (funct == 6'h00 || funct == 6'h02 || funct == 6'h03)) begin
               dec_alusel  = SEL_SHIFT;
               dec_aluop   = (funct == 6'h00) ? OP_SLL : ((funct == 6'h02) ? OP_SRL : OP_SRA);
               rf_re2      = 1'b1;
               imm1        = DATA_W'(sa);
               dec_wreg    = 1'b1;
               dec_invalid = 1'b0;
            end else if (sa == 5'd0) begin
               case (funct)
                  6'h24, 6'h25, 6'h26, 6'h27: begin
                     dec_alusel  = SEL_LOGIC;
                     case (funct[1:0])
                        2'd0:    dec_aluop = OP_AND;
                        2'd1:    dec_aluop = OP_OR;
                        2'd2:    dec_aluop = OP_XOR;
                        default: dec_aluop = OP_NOR;
                     endcase
                     rf_re1      = 1'b1;
                     rf_re2      = 1'b1;
                     dec_wreg    = 1'b1;
                     dec_invalid = 1'b0;
                  end
                  6'h04, 6'h06, 6'h07: begin
                     dec_alusel  = SEL_SHIFT;
                     dec_aluop   = (funct == 6'h04) ? OP_SLL : ((funct == 6'h06) ? OP_SRL : OP_SRA);
                     rf_re1      = 1'b1;
                     rf_re2      = 1'b1;
                     dec_wreg    = 1'b1;
                     dec_invalid = 1'b0;
                  end
                  6'h0F: begin
                     rf_re2      = 1'b1;
                     dec_invalid = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
         6'h0C, 6'h0D, 6'h0E: begin
            dec_alusel  = SEL_LOGIC;
            dec_aluop   = (opcode == 6'h0C) ? OP_AND : ((opcode == 6'h0D) ? OP_OR : OP_XOR);
            rf_re1      = 1'b1;
            imm2        = DATA_W'(imm16);
            dec_wd      = RA_W'(in_inst[20:16]);
            dec_wreg    = 1'b1;
            dec_invalid = 1'b0;
         end
         6'h0F: begin
            // LUI is executed as rs | (imm << 16); rs is $0 in well-formed code
            dec_alusel  = SEL_LOGIC;
            dec_aluop   = OP_OR;
            rf_re1      = 1'b1;
            imm2        = DATA_W'({imm16, 16'h0000});
            dec_wd      = RA_W'(in_inst[20:16]);
            dec_wreg    = 1'b1;
            dec_invalid = 1'b0;
         end
         6'h33:   dec_invalid = 1'b0;
         default: ;
      endcase
   end

   logic [RA_W-1:0]   src_addr [NUM_FWD];
   logic [DATA_W-1:0] src_data [NUM_FWD];

   for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_src
      assign src_addr[gi] = fwd_waddr[gi*RA_W +: RA_W];
      assign src_data[gi] = fwd_wdata[gi*DATA_W +: DATA_W];
   end

   // Returns {pending_load, operand}; scanning from the oldest source lets the youngest win.
   function automatic logic [DATA_W:0] resolve(input logic re, input logic [RA_W-1:0] ra,
                                               input logic [DATA_W-1:0] imm,
                                               input logic [DATA_W-1:0] rd);
      logic [DATA_W-1:0] val;
      logic              load;
      val  = rd;
      load = 1'b0;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (fwd_wen[i] && src_addr[i] == ra) begin
            val  = src_data[i];
            load = fwd_is_load[i];
         end
      end
      if (!re) begin
         val  = imm;
         load = 1'b0;
      end else if (ra == '0) begin
         val  = '0;
         load = 1'b0;
      end
      return {load, val};
   endfunction

   logic              load1, load2, stall, capture;
   logic [DATA_W-1:0] src1, src2;
   assign {load1, src1} = resolve(rf_re1, rf_ra1, imm1, rf_rd1);
   assign {load2, src2} = resolve(rf_re2, rf_ra2, imm2, rf_rd2);
   assign stall         = load1 | load2;

   logic              out_valid_reg;
   logic [15:0]       stall_cnt_reg, stall_cnt_next;
   logic [7:0]        aluop_reg;
   logic [2:0]        alusel_reg;
   logic [DATA_W-1:0] src1_reg, src2_reg;
   logic [RA_W-1:0]   wd_reg;
   logic              wreg_reg, invalid_reg;
   logic [31:0]       pc_reg;

   assign in_ready = !reset && !flush && !stall && (!out_valid_reg || out_ready);
   assign capture  = in_valid && in_ready;
   assign stall_cnt_next = (in_valid && stall && stall_cnt_reg != 16'hFFFF) ? stall_cnt_reg + 16'd1
                                                                          : stall_cnt_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_reg <= 1'b0;
         aluop_reg     <= '0;
         alusel_reg    <= '0;
         src1_reg      <= '0;
         src2_reg      <= '0;
         wd_reg        <= '0;
         wreg_reg      <= 1'b0;
         pc_reg        <= '0;
         invalid_reg   <= 1'b0;
         stall_cnt_reg <= '0;
      end else begin
         stall_cnt_reg <= stall_cnt_next;
         if (flush) begin
            out_valid_reg <= 1'b0;
         end else if (capture) begin
            out_valid_reg <= 1'b1;
            aluop_reg     <= dec_aluop;
            alusel_reg    <= dec_alusel;
            src1_reg      <= src1;
            src2_reg      <= src2;
            wd_reg        <= dec_wd;
            wreg_reg      <= dec_wreg;
            pc_reg        <= in_pc;
            invalid_reg   <= dec_invalid;
         end else if (out_ready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign out_valid   = out_valid_reg;
   assign out_aluop   = aluop_reg;
   assign out_alusel  = alusel_reg;
   assign out_src1    = src1_reg;
   assign out_src2    = src2_reg;
   assign out_wd      = wd_reg;
   assign out_wreg    = wreg_reg;
   assign out_pc      = pc_reg;
   assign out_invalid = invalid_reg;
   assign stall_cnt   = stall_cnt_reg;

endmodule

// File: doc/id_pipe.md
ID_PIPE -- requirements
Module: id_pipe

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; legal values >= 32.
REQ-002 Parameter RA_W, default 5, register address width.
REQ-003 Parameter NUM_FWD, default 2, number of forwarding sources; index 0 is the youngest and has the highest priority.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  drop the held entry and any incoming instruction this cycle.
REQ-007 in_valid/in_ready  input/output  1/1  instruction handshake.
REQ-008 in_pc/in_inst  input  32/32  fetched PC and instruction word.
REQ-009 rf_re1, rf_re2  output  1  combinational register-file read enables.
REQ-010 rf_ra1, rf_ra2  output  RA_W  combinational read addresses (inst[25:21], inst[20:16]).
REQ-011 rf_rd1, rf_rd2  input  DATA_W  register-file read data, same cycle.
REQ-012 fwd_wen, fwd_is_load  input  NUM_FWD  per-source write-enable and pending-load flag.
REQ-013 fwd_waddr/fwd_wdata  input  NUM_FWD*RA_W / NUM_FWD*DATA_W  packed destinations and data; source i occupies slice i.
REQ-014 out_valid/out_ready  output/input  1/1  decoded-bundle handshake.
REQ-015 out_aluop  output  8; out_alusel  output  3; out_src1, out_src2  output  DATA_W; out_wd  output  RA_W; out_wreg  output  1; out_pc  output  32; out_invalid  output  1.
REQ-016 stall_cnt  output  16  count of load-use stall cycles, saturating.

Function
REQ-017 The decode encodings SHALL be as follows. aluop: NOP 0x00, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLL 0x7C, SRL 0x02, SRA 0x03. alusel: NOP 0, LOGIC 1, SHIFT 2.
REQ-018 SPECIAL (opcode 0) with inst[10:6]=0: funct 0x25/0x24/0x26/0x27 SHALL decode to OR/AND/XOR/NOR with LOGIC select, and 0x04/0x06/0x07 to SLLV/SRLV/SRAV with SHIFT select. These read rs and rt and write rd with wreg=1.
REQ-019 SYNC (funct 0x0F) SHALL read rt and produce NOP with wreg=0.
REQ-020 inst[31:21]=0 with funct 0x00/0x02/0x03 SHALL decode to SLL/SRL/SRA: rt read on port 2, port 1 disabled, src1 = zero-extended sa (inst[10:6]), writes rd. All-zero instruction = SLL $0 (harmless).
REQ-021 ORI 0x0D, ANDI 0x0C, XORI 0x0E SHALL read rs only, src2 = zero-extended imm16, and write rt.
REQ-022 LUI 0x0F SHALL decode as OR, src2 = imm16<<16 (upper DATA_W-32 bits zero), write rt.
REQ-023 PREF 0x33 SHALL decode to NOP with no reads and wreg=0.
REQ-024 Any other encoding SHALL give out_invalid=1, aluop NOP, alusel NOP, wreg=0, no reads; it still completes the handshake.
REQ-025 Operand select for a read port, in priority order:
- port disabled -> immediate (0 if the instruction has none);
- address 0 -> 0, never forwarded;
- lowest-index source with fwd_wen=1 and matching address -> that source's data;
- otherwise -> rf data.
REQ-026 Load-use stall SHALL assert when an enabled port's highest-priority matching source has fwd_is_load=1; port address 0 is excluded.
REQ-027 in_ready SHALL equal !reset && !flush && !stall && (!out_valid || out_ready).
REQ-028 Output register update:
- in_valid && in_ready: register the decoded bundle and in_pc, set out_valid (latency 1 cycle);
- else if out_ready: clear out_valid;
- otherwise: hold all outputs unchanged.
REQ-029 flush SHALL clear out_valid on the next edge and SHALL capture nothing that cycle; flush has priority over capture.
REQ-030 stall_cnt SHALL increment each cycle that in_valid && stall, and saturate at 0xFFFF.
REQ-031 rf_re*/rf_ra* SHALL follow in_inst combinationally regardless of in_valid.

Reset
REQ-032 On reset: out_valid=0, out_aluop=0, out_alusel=0, out_src1=0, out_src2=0, out_wd=0, out_wreg=0, out_pc=0, out_invalid=0, stall_cnt=0; in_ready=0 during reset.
REQ-033 Reset asserted mid-stall or mid-backpressure SHALL discard the held bundle; the first instruction after deassert is captured normally.

Verification
REQ-034 Basic ORI. Stimulus: in_inst=0x34211234, rf_rd1=0x000000FF, no forwarding. Response: next cycle out_valid=1, aluop=0x25, alusel=1, src1=0xFF, src2=0x1234, wd=1, wreg=1.
REQ-035 Forwarding priority. Stimulus: same ORI, fwd0 (addr 1, data 0xAAAA0000) and fwd1 (addr 1, data 0x5555) both enabled. Response: src1=0xAAAA0000. With fwd0 disabled: src1=0x5555.
REQ-036 Load-use stall. Stimulus: fwd0 addr 1 with is_load=1 for 3 cycles. Response: in_ready=0 for those 3 cycles, no capture, stall_cnt=3; capture the cycle after is_load drops.
REQ-037 Shift and backpressure. Stimulus: in_inst=0x00021080, rf_rd2=0x3, then out_ready=0 for 4 cycles. Response: aluop=0x7C, src1=2, src2=3, wd=2; outputs stable and in_ready=0 throughout.
REQ-038 Invalid and flush. Stimulus: opcode 0x3F. Response: out_invalid=1, wreg=0. Stimulus: flush while out_valid=1 and in_valid=1. Response: out_valid=0 next cycle, nothing captured.
REQ-039 Reset mid-operation. Stimulus: reset during backpressure. Response: all outputs 0 next cycle; stall_cnt=0.
